// File: rtl/fib_calc_pkg.sv
// rtl/fib_calc_pkg.sv - shared widths and state encoding for the Fibonacci engine
package fib_calc_pkg;

  localparam int FIB_W = 20;
  localparam int IDX_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } fib_state_e;

endpackage

// File: rtl/fib_calc_if.sv
// rtl/fib_calc_if.sv - start/ready/done_tick handshake and result bus for fib_calc
interface fib_calc_if #(
  parameter int W  = fib_calc_pkg::FIB_W,
  parameter int IW = fib_calc_pkg::IDX_W
);

  logic          start;
  logic [IW-1:0] i;
  logic          ready;
  logic          done_tick;
  logic [W-1:0]  f;
  logic          ovf;

  modport master (
    output start, i,
    input  ready, done_tick, f, ovf
  );

  modport slave (
    input  start, i,
    output ready, done_tick, f, ovf
  );

endinterface

// File: rtl/fib_calc.sv
// rtl/fib_calc.sv - iterative Fibonacci engine, one addition per clock, saturating on overflow
module fib_calc
  import fib_calc_pkg::*;
#(
  parameter int W  = FIB_W,
  parameter int IW = IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  fib_calc_if.slave   bus
);

  fib_state_e    state_q, state_d;
  logic [W-1:0]  t0_q, t0_d;
  logic [W-1:0]  t1_q, t1_d;
  logic [IW-1:0] n_q, n_d;
  logic [W-1:0]  f_q, f_d;
  logic          ovf_q, ovf_d;
  logic [W:0]    sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t0_q    <= '0;
      t1_q    <= '0;
      n_q     <= '0;
      f_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      n_q     <= n_d;
      f_q     <= f_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    n_d     = n_q;
    f_d     = f_q;
    ovf_d   = ovf_q;
    sum     = {1'b0, t0_q} + {1'b0, t1_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          t0_d    = '0;
          t1_d    = {{(W-1){1'b0}}, 1'b1};
          n_d     = bus.i;
          f_d     = '0;
          ovf_d   = 1'b0;
          state_d = OP;
        end
      end
      OP: begin
        if (n_q == '0) begin
          f_d     = t0_q;
          state_d = DONE;
        // On the last step the new t1 is never read, so its carry must not flag fib(i) as too big
        end else if (sum[W] && (n_q != IW'(1))) begin
          f_d     = '1;
          ovf_d   = 1'b1;
          state_d = DONE;
        end else begin
          t0_d = t1_q;
          t1_d = sum[W-1:0];
          n_d  = n_q - IW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.done_tick = (state_q == DONE);
  assign bus.f         = f_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fib_calc.sv
// tb/tb_fib_calc.sv - directed self-checking bench for fib_calc
module tb_fib_calc;
  import fib_calc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  fib_calc_if #(.W(FIB_W), .IW(IDX_W)) bus ();

  fib_calc #(.W(FIB_W), .IW(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: raises start for one cycle, then waits for done_tick.
  // Latency counts posedges from the accept edge up to the one that raises done_tick.
  task automatic run(input string tag, input int idx, input int exp_f, input bit exp_ovf,
                     input int exp_lat, input bit exact_lat);
    int  lat;
    bit  seen;
    bit  ready_low;
    bus.start = 1'b1;
    bus.i     = IDX_W'(idx);
    @(negedge clk);
    bus.start = 1'b0;
    lat       = 1;
    seen      = bus.done_tick;
    ready_low = !bus.ready;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      seen = bus.done_tick;
      if (bus.ready) ready_low = 1'b0;
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (exact_lat) check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    else           check_eq({tag, "_latency_bound"}, 32'(lat <= exp_lat), 32'd1);
    check_eq({tag, "_ready_low_in_op"}, 32'(ready_low), 32'd1);
    check_eq({tag, "_f"}, 32'(bus.f), 32'(exp_f));
    check_eq({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
    @(negedge clk);
    check_eq({tag, "_done_one_cycle"}, 32'(bus.done_tick), 32'd0);
    check_eq({tag, "_ready_after"}, 32'(bus.ready), 32'd1);
  endtask

  initial begin
    int dones;
    int bin;
    bus.start = 1'b0;
    bus.i     = '0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("reset_ready", 32'(bus.ready), 32'd1);
    check_eq("reset_done", 32'(bus.done_tick), 32'd0);
    check_eq("reset_f", 32'(bus.f), 32'd0);
    check_eq("reset_ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run("i0", 0, 0, 1'b0, 2, 1'b1);
    run("i1", 1, 1, 1'b0, 3, 1'b1);
    run("i10", 10, 32'h37, 1'b0, 12, 1'b1);
    run("i30", 30, 32'hCB228, 1'b0, 32, 1'b1);
    run("i31", 31, 32'hFFFFF, 1'b1, 33, 1'b0);
    run("i99", 99, 32'hFFFFF, 1'b1, 33, 1'b0);
    run("i127", 127, 32'hFFFFF, 1'b1, 33, 1'b0);

    // start during OP must be ignored
    bus.start = 1'b1;
    bus.i     = IDX_W'(20);
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 4) begin
        bus.start = 1'b1;
        bus.i     = IDX_W'(5);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done_tick) dones++;
    end
    check_eq("mid_op_start_dones", 32'(dones), 32'd1);
    check_eq("mid_op_start_f", 32'(bus.f), 32'h1A6D);

    // reset in the 5th OP cycle aborts the run
    bus.start = 1'b1;
    bus.i     = IDX_W'(25);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_ready", 32'(bus.ready), 32'd1);
    check_eq("abort_f", 32'(bus.f), 32'd0);
    check_eq("abort_ovf", 32'(bus.ovf), 32'd0);
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.done_tick) dones++;
      @(negedge clk);
    end
    check_eq("abort_no_done", 32'(dones), 32'd0);
    run("i25_after_abort", 25, 32'h12511, 1'b0, 27, 1'b1);

    // converter handoff: digits 2,5 give bin 25 on its done_tick
    bin = 2 * 10 + 5;
    run("conv_25", bin, 32'h12511, 1'b0, 27, 1'b1);

    // back-to-back: start in DONE ignored, start the cycle after accepted
    bus.start = 1'b1;
    bus.i     = IDX_W'(3);
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    while (!bus.done_tick && dones < 20) begin
      @(negedge clk);
      dones++;
    end
    check_eq("b2b_first_done", 32'(bus.done_tick), 32'd1);
    bus.start = 1'b1;
    bus.i     = IDX_W'(7);
    check_eq("b2b_ready_in_done", 32'(bus.ready), 32'd0);
    @(negedge clk);
    check_eq("b2b_ignored_idle", 32'(bus.ready), 32'd1);
    check_eq("b2b_f_held", 32'(bus.f), 32'd2);
    run("b2b_i7", 7, 13, 1'b0, 9, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
